l1_cache: RTL
=============

L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, number of direct-mapped lines (power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock; only clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 SHALL have port mem_write  input  1  CPU write request, held until mem_resp.
REQ-006 SHALL have port mem_byte_enable  input  4  byte lanes for writes.
REQ-007 SHALL have port mem_address  input  32  CPU byte address; bits [1:0] ignored.
REQ-008 SHALL have port mem_wdata  input  32  CPU write data.
REQ-009 SHALL have port mem_rdata  output  32  selected word of indexed line.
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion strobe to CPU.
REQ-011 SHALL have port pmem_read  output  1  line fill request.
REQ-012 SHALL have port pmem_write  output  1  line writeback request.
REQ-013 SHALL have port pmem_address  output  32  line-aligned address, bits [4:0] = 0.
REQ-014 SHALL have port pmem_wdata  output  256  victim line data.
REQ-015 SHALL have port pmem_rdata  input  256  fill line data.
REQ-016 SHALL have port pmem_resp  input  1  one-cycle completion strobe from memory.

Function
REQ-017 SHALL split the address as tag [31:5+log2(NUM_SETS)], index [4+log2(NUM_SETS):5], word [4:2]; the tag is 24 bits at the default.
REQ-018 SHALL keep per line: valid, dirty, tag, and 256-bit data in flip-flops with combinational read.
REQ-019 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-020 IDLE: hit = valid & tag match & (mem_read | mem_write); on a hit, mem_resp=1 in the same cycle (combinational).
REQ-021 On a read hit, mem_rdata SHALL be word [word] of the line in the same cycle.
REQ-022 On a write hit, the clock edge SHALL merge mem_wdata into the word under mem_byte_enable and set dirty=1.
REQ-023 On an IDLE miss with the victim valid & dirty, the next state SHALL be WRITEBACK; otherwise ALLOCATE.
REQ-024 In WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line; on pmem_resp go to ALLOCATE and clear dirty.
REQ-025 In ALLOCATE: pmem_read=1, pmem_address={req tag, index, 5'b0}; on pmem_resp load line, tag, valid=1, dirty=0, and go to IDLE.
REQ-026 After a fill, the request SHALL be served as a hit in IDLE; miss latency = writeback + fill + 1 cycle.
REQ-027 pmem_read and pmem_write SHALL never be high together and SHALL be 0 in IDLE.
REQ-028 mem_resp SHALL be 0 outside IDLE.
REQ-029 mem_read and mem_write both high SHALL be treated as a write.
REQ-030 Once started, a miss sequence SHALL complete even if the CPU request drops.
REQ-031 pmem_resp in IDLE SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE and clear all valid and dirty bits; tags and data are not reset.
REQ-033 After reset: mem_resp, pmem_read, pmem_write = 0; pmem_address = 0 while idle.
REQ-034 rst during WRITEBACK or ALLOCATE SHALL abort the sequence, with pmem requests low the next cycle and no line updated.

Structure
REQ-035 The state enum and the line-width/offset constants SHALL reside in rv32i_types.
REQ-036 The design SHALL split into one sub-module l1_cache_control (FSM) with the arrays/muxes in l1_cache.
REQ-037 mp2 SHALL connect to the CPU side unchanged; the physical memory model attaches to the pmem side.

Verification
REQ-038 Read miss to 0x0000_0124 on a clean cache -> pmem_read with pmem_address 0x0000_0120; pmem_resp with word1=0xDEADBEEF -> mem_resp one cycle later, mem_rdata 0xDEADBEEF.
REQ-039 Write hit 0x0000_0124, byte_enable 4'b0011, wdata 0x1234_5678 -> same-cycle mem_resp; a subsequent read returns 0xDEAD5678.
REQ-040 Read 0x0000_1124 (same index, different tag) after REQ-039 -> WRITEBACK to 0x0000_0120 with word1 0xDEAD5678, then fill from 0x0000_1120.
REQ-041 Clean-victim conflict miss -> no pmem_write, ALLOCATE only.
REQ-042 rst asserted mid-ALLOCATE -> pmem_read low next cycle; a re-read of the same address misses again.
REQ-043 Random reads and writes against a reference memory model over 10k cycles -> all data matches and the pmem read/write exclusivity assertion always holds.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared cache types: controller states and line geometry.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } cache_state_e;

   localparam int LINE_BITS   = 256;
   localparam int OFFSET_BITS = 5;
   localparam int WORD_BITS   = 32;

endpackage

// File: rtl/l1_cache_control.sv
// Miss sequencer for the direct-mapped cache.
module l1_cache_control
   import rv32i_types::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         req,
   input  logic         hit,
   input  logic         victim_dirty,
   input  logic         pmem_resp,
   output cache_state_e state,
   output logic         pmem_read,
   output logic         pmem_write
);

   cache_state_e state_q;
   cache_state_e state_d;
   logic         pmem_read_q;
   logic         pmem_write_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req && !hit)
               state_d = victim_dirty ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            if (pmem_resp) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request strobes are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pmem_read_q  <= (state_d == ALLOCATE);
         pmem_write_q <= (state_d == WRITEBACK);
      end
   end

   assign state      = state_q;
   assign pmem_read  = pmem_read_q;
   assign pmem_write = pmem_write_q;

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back L1 cache: line arrays, hit logic and
// pmem muxing around the l1_cache_control sequencer.
module l1_cache
   import rv32i_types::*;
#(
   parameter int NUM_SETS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [3:0]           mem_byte_enable,
   input  logic [31:0]          mem_address,
   input  logic [31:0]          mem_wdata,
   output logic [31:0]          mem_rdata,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [31:0]          pmem_address,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

   cache_state_e         state;
   logic [LINE_BITS-1:0] data_q [NUM_SETS];
   logic [LINE_BITS-1:0] data_d [NUM_SETS];
   logic [TAG_W-1:0]     tag_q  [NUM_SETS];
   logic [TAG_W-1:0]     tag_d  [NUM_SETS];
   logic [NUM_SETS-1:0]  valid_q, valid_d;
   logic [NUM_SETS-1:0]  dirty_q, dirty_d;
   logic [31:OFFSET_BITS] miss_q, miss_d;

   logic [IDX_W-1:0] idx, m_idx;
   logic [TAG_W-1:0] tag, m_tag;
   logic [2:0]       word;
   logic             req, hit, unused_addr;

   assign idx   = mem_address[OFFSET_BITS +: IDX_W];
   assign tag   = mem_address[31 -: TAG_W];
   assign word  = mem_address[4:2];
   assign m_idx = miss_q[OFFSET_BITS +: IDX_W];
   assign m_tag = miss_q[31 -: TAG_W];
   assign unused_addr = ^mem_address[1:0];

   assign req = mem_read | mem_write;
   assign hit = req && valid_q[idx] && (tag_q[idx] == tag);

   assign mem_resp   = (state == IDLE) && hit;
   assign mem_rdata  = data_q[idx][{word, 5'b0} +: WORD_BITS];
   assign pmem_wdata = data_q[m_idx];

   // The miss line is latched so a dropped CPU request can't retarget it.
   assign miss_d = (state == IDLE) ? mem_address[31:OFFSET_BITS] : miss_q;

   always_comb begin
      case (state)
         WRITEBACK: pmem_address = {tag_q[m_idx], m_idx, 5'b0};
         ALLOCATE:  pmem_address = {m_tag, m_idx, 5'b0};
         default:   pmem_address = '0;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (mem_resp && mem_write) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b])
               data_d[idx][{word, b[1:0], 3'b0} +: 8] = mem_wdata[8*b +: 8];
         end
         dirty_d[idx] = 1'b1;
      end
      if (state == WRITEBACK && pmem_resp)
         dirty_d[m_idx] = 1'b0;
      if (state == ALLOCATE && pmem_resp) begin
         data_d[m_idx]  = pmem_rdata;
         tag_d[m_idx]   = m_tag;
         valid_d[m_idx] = 1'b1;
         dirty_d[m_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
         miss_q  <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         miss_q  <= miss_d;
      end
   end

   // Contents carry no reset value, but an edge under reset must not
   // commit a half-finished fill.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q <= data_d;
         tag_q  <= tag_d;
      end
   end

   l1_cache_control u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .hit          (hit),
      .victim_dirty (valid_q[idx] & dirty_q[idx]),
      .pmem_resp    (pmem_resp),
      .state        (state),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write)
   );

endmodule
